// File: rtl/axil_ram_slv_if.sv
// AXI4-Lite bus bundle shared by the RAM responder and its initiators.
// Write (AW/W/B) and read (AR/R) halves are exposed as separate modports.
interface axil_interface_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int USER_W = 1
);
  localparam int STRB_W = DATA_W / 8;

  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic [USER_W-1:0] awuser;
  logic              awvalid;
  logic              awready;
  logic [DATA_W-1:0] wdata;
  logic [STRB_W-1:0] wstrb;
  logic [USER_W-1:0] wuser;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic [USER_W-1:0] buser;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic [USER_W-1:0] aruser;
  logic              arvalid;
  logic              arready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [USER_W-1:0] ruser;
  logic              rvalid;
  logic              rready;

  modport wr_slv (
    input  awaddr, awprot, awuser, awvalid,
    input  wdata, wstrb, wuser, wvalid,
    input  bready,
    output awready, wready,
    output bresp, buser, bvalid
  );

  modport rd_slv (
    input  araddr, arprot, aruser, arvalid,
    input  rready,
    output arready,
    output rdata, rresp, ruser, rvalid
  );

  modport wr_mst (
    output awaddr, awprot, awuser, awvalid,
    output wdata, wstrb, wuser, wvalid,
    output bready,
    input  awready, wready,
    input  bresp, buser, bvalid
  );

  modport rd_mst (
    output araddr, arprot, aruser, arvalid,
    output rready,
    input  arready,
    input  rdata, rresp, ruser, rvalid
  );
endinterface

// File: rtl/axil_ram_slv.sv
// AXI4-Lite word-RAM responder: independent write and read channels,
// byte-strobed writes, 1-cycle read-first reads, SLVERR beyond the RAM.
module axil_ram_slv #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 64,
  parameter int MEM_WORDS_W = 10,
  parameter int STRB_W      = DATA_W / 8
) (
  input logic               clk,
  input logic               rst,
  axil_interface_if.wr_slv  s_axil_wr,
  axil_interface_if.rd_slv  s_axil_rd
);
  localparam int ADDR_LSB = $clog2(STRB_W);
  localparam int HI       = ADDR_LSB + MEM_WORDS_W;
  localparam int DEPTH    = 1 << MEM_WORDS_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              aw_hold_q, aw_hold_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic              w_hold_q, w_hold_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0] wstrb_q, wstrb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rvalid_q, rvalid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic                   aw_hs, w_hs, ar_hs;
  logic                   commit, mem_we;
  logic                   aw_oor, ar_oor;
  logic [MEM_WORDS_W-1:0] aw_word, ar_word;
  logic                   arready;

  assign aw_hs   = s_axil_wr.awvalid && !aw_hold_q;
  assign w_hs    = s_axil_wr.wvalid && !w_hold_q;
  assign arready = !rvalid_q || s_axil_rd.rready;
  assign ar_hs   = s_axil_rd.arvalid && arready;

  assign aw_word = awaddr_q[HI-1:ADDR_LSB];
  assign aw_oor  = |awaddr_q[ADDR_W-1:HI];
  assign ar_word = s_axil_rd.araddr[HI-1:ADDR_LSB];
  assign ar_oor  = |s_axil_rd.araddr[ADDR_W-1:HI];

  assign commit = aw_hold_q && w_hold_q
               && (!bvalid_q || s_axil_wr.bready);
  // reset discards a held pair, so it must not reach the RAM
  assign mem_we = commit && !aw_oor && !rst;

  always_comb begin
    aw_hold_d = aw_hold_q;
    awaddr_d  = awaddr_q;
    w_hold_d  = w_hold_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    if (aw_hs) begin
      aw_hold_d = 1'b1;
      awaddr_d  = s_axil_wr.awaddr;
    end
    if (w_hs) begin
      w_hold_d = 1'b1;
      wdata_d  = s_axil_wr.wdata;
      wstrb_d  = s_axil_wr.wstrb;
    end
    if (commit) begin
      aw_hold_d = 1'b0;
      w_hold_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_oor ? 2'b10 : 2'b00;
    end else if (s_axil_wr.bready) begin
      bvalid_d  = 1'b0;
    end
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_oor ? 2'b10 : 2'b00;
      rdata_d  = ar_oor ? '0 : mem[ar_word];
    end else if (s_axil_rd.rready) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      aw_hold_q <= 1'b0;
      awaddr_q  <= '0;
      w_hold_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      aw_hold_q <= aw_hold_d;
      awaddr_q  <= awaddr_d;
      w_hold_q  <= w_hold_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb_q[i]) begin
          mem[aw_word][i*8 +: 8] <= wdata_q[i*8 +: 8];
        end
      end
    end
  end

  assign s_axil_wr.awready = !aw_hold_q;
  assign s_axil_wr.wready  = !w_hold_q;
  assign s_axil_wr.bvalid  = bvalid_q;
  assign s_axil_wr.bresp   = bresp_q;
  assign s_axil_wr.buser   = '0;
  assign s_axil_rd.arready = arready;
  assign s_axil_rd.rvalid  = rvalid_q;
  assign s_axil_rd.rresp   = rresp_q;
  assign s_axil_rd.rdata   = rdata_q;
  assign s_axil_rd.ruser   = '0;

  logic unused_ok;
  assign unused_ok = ^{s_axil_wr.awprot, s_axil_wr.awuser,
                       s_axil_wr.wuser, s_axil_rd.arprot,
                       s_axil_rd.aruser, awaddr_q[ADDR_LSB-1:0],
                       s_axil_rd.araddr[ADDR_LSB-1:0]};
endmodule

// File: tb/tb_axil_ram_slv.sv
// Bench for axil_ram_slv: transaction-level memory model checked every
// cycle, plus directed scenarios with literal expected values.
module tb_axil_ram_slv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  axil_interface_if #(.DATA_W(64), .ADDR_W(64)) bus ();

  axil_ram_slv #(
    .DATA_W(64), .ADDR_W(64), .MEM_WORDS_W(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_axil_wr(bus),
    .s_axil_rd(bus)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [63:0] mem_m [1024];
  logic [63:0] awq [$];
  logic [63:0] wdq [$];
  logic [7:0]  wsq [$];
  logic [63:0] exp_rdata = '0;
  logic [1:0]  exp_rresp = '0;
  logic [1:0]  exp_bresp = '0;
  logic        started   = 1'b0;

  function automatic logic is_oor(input logic [63:0] a);
    return (a >> 13) != 64'd0;
  endfunction

  function automatic int word_of(input logic [63:0] a);
    return int'((a >> 3) & 64'h3FF);
  endfunction

  always @(posedge clk) begin : compare
    logic exp_bv, exp_rv, new_b;
    logic [63:0] a, d;
    logic [7:0]  s;
    exp_bv = 1'b0;
    exp_rv = 1'b0;
    new_b  = 1'b0;
    if (rst) begin
      started = 1'b1;
      awq.delete();
      wdq.delete();
      wsq.delete();
    end else begin
      // a complete pair finishes on this edge if the B slot is free
      new_b  = awq.size() > 0 && wdq.size() > 0
            && (!bus.bvalid || bus.bready);
      exp_bv = new_b || (bus.bvalid && !bus.bready);
      exp_rv = bus.rvalid && !bus.rready;
      if (bus.arvalid && bus.arready) begin
        exp_rv    = 1'b1;
        exp_rresp = is_oor(bus.araddr) ? 2'b10 : 2'b00;
        exp_rdata = is_oor(bus.araddr) ? 64'd0
                  : mem_m[word_of(bus.araddr)];
      end
      if (bus.awvalid && bus.awready) awq.push_back(bus.awaddr);
      if (bus.wvalid && bus.wready) begin
        wdq.push_back(bus.wdata);
        wsq.push_back(bus.wstrb);
      end
    end
    #1;
    if (started) begin
      if (new_b) begin
        a = awq.pop_front();
        d = wdq.pop_front();
        s = wsq.pop_front();
        exp_bresp = is_oor(a) ? 2'b10 : 2'b00;
        if (!is_oor(a))
          for (int i = 0; i < 8; i++)
            if (s[i]) mem_m[word_of(a)][i*8 +: 8] = d[i*8 +: 8];
      end
      chk("bvalid", 64'(bus.bvalid), 64'(exp_bv));
      if (exp_bv && bus.bvalid)
        chk("bresp", 64'(bus.bresp), 64'(exp_bresp));
      chk("rvalid", 64'(bus.rvalid), 64'(exp_rv));
      if (exp_rv && bus.rvalid) begin
        chk("rdata", bus.rdata, exp_rdata);
        chk("rresp", 64'(bus.rresp), 64'(exp_rresp));
      end
      chk("awready", 64'(bus.awready), 64'(awq.size() == 0));
      chk("wready", 64'(bus.wready), 64'(wdq.size() == 0));
      chk("arready", 64'(bus.arready),
          64'(!bus.rvalid || bus.rready));
    end
  end

  // ---------------- stimulus ----------------
  task automatic wr(input logic [63:0] a, input logic [63:0] d,
                    input logic [7:0] s, output logic [1:0] resp);
    logic aw_done, w_done, got;
    aw_done = 1'b0;
    w_done  = 1'b0;
    got     = 1'b0;
    resp    = 2'b11;
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = a;
    bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = s;
    bus.bready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (bus.awvalid && bus.awready) aw_done = 1'b1;
      if (bus.wvalid && bus.wready) w_done = 1'b1;
      if (bus.bvalid && bus.bready) begin
        resp = bus.bresp;
        got  = 1'b1;
        break;
      end
      @(negedge clk);
      if (aw_done) bus.awvalid = 1'b0;
      if (w_done) bus.wvalid = 1'b0;
    end
    if (!got) begin
      errors++;
      $display("FAIL wr_timeout: got no B for %h expected one", a);
    end
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic rd(input logic [63:0] a, output logic [63:0] d,
                    output logic [1:0] resp);
    logic got_ar, got;
    got_ar = 1'b0;
    got    = 1'b0;
    d      = 'x;
    resp   = 2'b11;
    @(negedge clk);
    bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk);
      if (got_ar && bus.rvalid && bus.rready) begin
        d = bus.rdata;
        resp = bus.rresp;
        got = 1'b1;
        break;
      end
      if (bus.arvalid && bus.arready) got_ar = 1'b1;
      @(negedge clk);
      if (got_ar) bus.arvalid = 1'b0;
    end
    if (!got) begin
      errors++;
      $display("FAIL rd_timeout: got no R for %h expected one", a);
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
  endtask

  initial begin
    logic [63:0] d;
    logic [1:0]  r;
    bus.awaddr = '0; bus.awprot = '0; bus.awuser = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wuser = '0;
    bus.wvalid = 1'b0; bus.bready = 1'b1;
    bus.araddr = '0; bus.arprot = '0; bus.aruser = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_bvalid", 64'(bus.bvalid), 64'd0);
    chk("rst_bresp", 64'(bus.bresp), 64'd0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'd0);
    chk("rst_rresp", 64'(bus.rresp), 64'd0);
    chk("rst_rdata", bus.rdata, 64'd0);
    chk("rst_ready", 64'({bus.awready, bus.wready, bus.arready}),
        64'd7);

    // full-word write then read back
    wr(64'h80, 64'h1122334455667788, 8'hFF, r);
    chk("t1_bresp", 64'(r), 64'd0);
    rd(64'h80, d, r);
    chk("t1_rdata", d, 64'h1122334455667788);
    chk("t1_rresp", 64'(r), 64'd0);

    // low four lanes only
    wr(64'h80, 64'hAAAAAAAAAAAAAAAA, 8'h0F, r);
    chk("t2_bresp", 64'(r), 64'd0);
    rd(64'h80, d, r);
    chk("t2_rdata", d, 64'h11223344AAAAAAAA);

    // W leads AW by 3 cycles, bready low for 5 cycles
    @(negedge clk);
    bus.bready = 1'b0;
    bus.wvalid = 1'b1; bus.wdata = 64'h0101010101010101;
    bus.wstrb = 8'hFF;
    @(negedge clk);
    chk("t3_wready_low", 64'(bus.wready), 64'd0);
    bus.wdata = 64'h0202020202020202;
    repeat (2) @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 64'h18;
    @(negedge clk);
    bus.awvalid = 1'b0;
    chk("t3_bvalid_pre", 64'(bus.bvalid), 64'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("t3_bvalid_hold", 64'(bus.bvalid), 64'd1);
      chk("t3_bresp_hold", 64'(bus.bresp), 64'd0);
      if (i == 0) begin
        chk("t3_w2_offer", 64'(bus.wready), 64'd1);
      end
      if (i == 1) begin
        chk("t3_w2_held", 64'(bus.wready), 64'd0);
        bus.awvalid = 1'b1; bus.awaddr = 64'h20;
      end
      if (i == 2) begin
        chk("t3_aw2_held", 64'(bus.awready), 64'd0);
        bus.awvalid = 1'b0;
        bus.wvalid = 1'b0;
      end
      @(negedge clk);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    chk("t3_b2_valid", 64'(bus.bvalid), 64'd1);
    @(negedge clk);
    chk("t3_b_done", 64'(bus.bvalid), 64'd0);
    rd(64'h18, d, r);
    chk("t3_rdata1", d, 64'h0101010101010101);
    rd(64'h20, d, r);
    chk("t3_rdata2", d, 64'h0202020202020202);

    // out-of-range write/read leave word 0 intact
    wr(64'h00, 64'h0123456789ABCDEF, 8'hFF, r);
    wr(64'h08, 64'hCAFEF00DDEADBEEF, 8'hFF, r);
    wr(64'h10, 64'h0F0E0D0C0B0A0908, 8'hFF, r);
    wr(64'h2000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, r);
    chk("t4_bresp", 64'(r), 64'd2);
    rd(64'h2000, d, r);
    chk("t4_rresp", 64'(r), 64'd2);
    chk("t4_rdata", d, 64'd0);
    rd(64'h00, d, r);
    chk("t4_word0", d, 64'h0123456789ABCDEF);

    // back-to-back reads, then backpressure
    @(negedge clk);
    bus.rready = 1'b1; bus.arvalid = 1'b1; bus.araddr = 64'h00;
    @(negedge clk);
    chk("t5_arready0", 64'(bus.arready), 64'd1);
    chk("t5_beat0", bus.rdata, 64'h0123456789ABCDEF);
    bus.araddr = 64'h08;
    @(negedge clk);
    chk("t5_arready1", 64'(bus.arready), 64'd1);
    chk("t5_beat1", bus.rdata, 64'hCAFEF00DDEADBEEF);
    bus.araddr = 64'h10;
    @(negedge clk);
    chk("t5_beat2", bus.rdata, 64'h0F0E0D0C0B0A0908);
    chk("t5_rvalid2", 64'(bus.rvalid), 64'd1);
    bus.rready = 1'b0; bus.araddr = 64'h18;
    repeat (2) begin
      @(negedge clk);
      chk("t5_arready_low", 64'(bus.arready), 64'd0);
      chk("t5_rdata_hold", bus.rdata, 64'h0F0E0D0C0B0A0908);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    chk("t5_beat3", bus.rdata, 64'h0101010101010101);
    @(negedge clk);

    // reset between acceptance and commit discards the write
    wr(64'h28, 64'h5555666677778888, 8'hFF, r);
    @(negedge clk);
    bus.awvalid = 1'b1; bus.awaddr = 64'h28;
    bus.wvalid = 1'b1; bus.wdata = 64'h9999999999999999;
    bus.wstrb = 8'hFF;
    @(negedge clk);
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_bvalid", 64'(bus.bvalid), 64'd0);
    chk("t6_awready", 64'(bus.awready), 64'd1);
    chk("t6_wready", 64'(bus.wready), 64'd1);
    rd(64'h28, d, r);
    chk("t6_old", d, 64'h5555666677778888);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
